// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory
// request in flight, and queues returned words in a 2-entry FIFO for decode.
module instr_fetch #(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [15:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [PC_W-1:0] if_pc,
  output logic [15:0]     if_instr,
  output logic [3:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2_imm
);

  typedef enum logic [1:0] {
    S_FETCH     = 2'd0,
    S_WAIT      = 2'd1,
    S_WAIT_DROP = 2'd2
  } state_t;

  state_t          state;
  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] req_pc;

  logic [PC_W-1:0] fifo_pc    [2];
  logic [15:0]     fifo_instr [2];
  logic            rd_ptr;
  logic            wr_ptr;
  logic [1:0]      count;

  logic issue;
  logic push;
  logic pop;

  // rst_n gates the strobe so no request leaks out while reset is held.
  assign issue = rst_n && (state == S_FETCH) && (count != 2'd2) && !redirect_valid;
  assign push  = (state == S_WAIT) && imem_rvalid && !redirect_valid;
  assign pop   = if_valid && if_ready;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  assign if_valid = (count != 2'd0) && !redirect_valid;
  assign if_pc    = fifo_pc[rd_ptr];
  assign if_instr = fifo_instr[rd_ptr];
  assign opcode   = if_instr[15:12];
  assign rd       = if_instr[11:8];
  assign rs1      = if_instr[7:4];
  assign rs2_imm  = if_instr[3:0];

  // Request tracker: the state records whether the in-flight response is wanted.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      if (state != S_FETCH) begin
        state <= imem_rvalid ? S_FETCH : S_WAIT_DROP;
      end
    end else begin
      case (state)
        S_FETCH: begin
          if (issue) begin
            state    <= S_WAIT;
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + PC_W'(1);
          end
        end
        S_WAIT, S_WAIT_DROP: begin
          if (imem_rvalid) begin
            state <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

  // 2-entry FIFO; a redirect empties it and realigns both pointers.
  // NOTE: the storage is reset because the head fields must read zero out of
  // reset; with only two entries this costs nothing meaningful.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= '0;
        fifo_instr[i] <= '0;
      end
    end else if (redirect_valid) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        fifo_pc[wr_ptr]    <= req_pc;
        fifo_instr[wr_ptr] <= imem_rdata;
        wr_ptr             <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
